// File: rtl/wb_sram_ctrl_if.sv
// Wishbone slave-0 bus plus 1RW SRAM macro pins for wb_sram_ctrl.
// slave = controller view, master = interconnect/SRAM-side view.
interface wb_sram_ctrl_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic [DW-1:0]   wb_dat_i;
    logic [AW-1:0]   wb_adr_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            sram_csb_o;
    logic            sram_web_o;
    logic [DW/8-1:0] sram_wmask_o;
    logic [AW-1:0]   sram_addr_o;
    logic [DW-1:0]   sram_din_o;
    logic [DW-1:0]   sram_dout_i;

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, sram_dout_i,
        output wb_dat_o, wb_ack_o, sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o,
               sram_din_o
    );

    modport master (
        output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, sram_dout_i,
        input  wb_dat_o, wb_ack_o, sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o,
               sram_din_o
    );
endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave to 1RW byte-masked SRAM bridge with configurable wait states.
// Define SRAM_DOUT_REG_EN to add a registered capture stage on the SRAM read data.
module wb_sram_ctrl #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned WAIT_CYC = 0
) (
    input logic           clk_i,
    input logic           rst_ni,
    wb_sram_ctrl_if.slave bus
);
    localparam int unsigned BW = DW / 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCESS = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
`ifdef SRAM_DOUT_REG_EN
    localparam logic [2:0] S_RCAP   = 3'd5;
`endif

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_we_q, op_we_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [BW-1:0] wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          access_done;
`ifdef SRAM_DOUT_REG_EN
    logic [DW-1:0] dout_q, dout_d;
`endif

    // Last cycle of the SRAM access window, with or without wait states.
    assign access_done = (state_q == S_ACCESS && cnt_q == 4'd0) ||
                         (state_q == S_WAIT && cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef SRAM_DOUT_REG_EN
        dout_d  = dout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    csb_d   = 1'b0;
                    web_d   = ~bus.wb_we_i;
                    addr_d  = bus.wb_adr_i;
                    din_d   = bus.wb_dat_i;
                    wmask_d = bus.wb_we_i ? bus.wb_sel_i : '0;
                    op_we_d = bus.wb_we_i;
                    cnt_d   = 4'(WAIT_CYC);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (cnt_q != 4'd0) state_d = S_WAIT;
            end
            S_WAIT: cnt_d = cnt_q - 4'd1;
`ifdef SRAM_DOUT_REG_EN
            S_RDATA: begin
                dout_d  = bus.sram_dout_i;
                state_d = S_RCAP;
            end
            S_RCAP: begin
                rdat_d  = dout_q;
                ack_d   = bus.wb_cyc_i;
                state_d = S_ACK;
            end
`else
            S_RDATA: begin
                rdat_d  = bus.sram_dout_i;
                ack_d   = bus.wb_cyc_i;
                state_d = S_ACK;
            end
`endif
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An abandoned cycle still finishes the SRAM access but never acks.
        if (access_done) begin
            if (op_we_q) begin
                ack_d   = bus.wb_cyc_i;
                state_d = S_ACK;
            end else begin
                state_d = S_RDATA;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_we_q <= 1'b0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

`ifdef SRAM_DOUT_REG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dout_q <= '0;
        else         dout_q <= dout_d;
    end
`endif

    assign bus.wb_ack_o     = ack_q;
    assign bus.wb_dat_o     = rdat_q;
    assign bus.sram_csb_o   = csb_q;
    assign bus.sram_web_o   = web_q;
    assign bus.sram_wmask_o = wmask_q;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_din_o   = din_q;
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: two instances (WAIT_CYC=0 and 3), behavioural SRAMs
// and an array-based reference memory; randomized traffic plus directed cases.
module tb_wb_sram_ctrl;
`ifdef SRAM_DOUT_REG_EN
    localparam int RdExtra = 1;
`else
    localparam int RdExtra = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0, dut_sel = 1'b0;
    logic [7:0] adr = 8'h00;
    logic [31:0] wdat = 32'h0;
    logic [3:0] sel = 4'h0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem0 [256] = '{default: 32'h0};
    logic [31:0] mem1 [256] = '{default: 32'h0};
    logic [31:0] refmem [2][256] = '{default: '{default: 32'h0}};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    logic [31:0] dout0 = 32'h0, dout1 = 32'h0;
    int acc0 = 0, acc1 = 0;

    always #5 clk = ~clk;

    wb_sram_ctrl_if #(.AW(8), .DW(32)) bus0 ();
    wb_sram_ctrl_if #(.AW(8), .DW(32)) bus1 ();

    wb_sram_ctrl #(.AW(8), .DW(32), .WAIT_CYC(0)) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
    wb_sram_ctrl #(.AW(8), .DW(32), .WAIT_CYC(3)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

    assign bus0.wb_cyc_i = cyc & ~dut_sel;
    assign bus0.wb_stb_i = stb & ~dut_sel;
    assign bus0.wb_we_i  = we;
    assign bus0.wb_adr_i = adr;
    assign bus0.wb_dat_i = wdat;
    assign bus0.wb_sel_i = sel;
    assign bus0.sram_dout_i = dout0;
    assign bus1.wb_cyc_i = cyc & dut_sel;
    assign bus1.wb_stb_i = stb & dut_sel;
    assign bus1.wb_we_i  = we;
    assign bus1.wb_adr_i = adr;
    assign bus1.wb_dat_i = wdat;
    assign bus1.wb_sel_i = sel;
    assign bus1.sram_dout_i = dout1;

    wire        ack_m = dut_sel ? bus1.wb_ack_o : bus0.wb_ack_o;
    wire        csb_m = dut_sel ? bus1.sram_csb_o : bus0.sram_csb_o;
    wire [31:0] dat_m = dut_sel ? bus1.wb_dat_o : bus0.wb_dat_o;

    // Behavioural 1RW SRAMs: sample on the rising edge while csb is low.
    always @(posedge clk) begin
        if (!bus0.sram_csb_o) begin
            acc0 <= acc0 + 1;
            if (!bus0.sram_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus0.sram_wmask_o[b])
                        mem0[bus0.sram_addr_o][8*b +: 8] <= bus0.sram_din_o[8*b +: 8];
            end else dout0 <= mem0[bus0.sram_addr_o];
        end
    end

    always @(posedge clk) begin
        if (!bus1.sram_csb_o) begin
            acc1 <= acc1 + 1;
            if (!bus1.sram_web_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus1.sram_wmask_o[b])
                        mem1[bus1.sram_addr_o][8*b +: 8] <= bus1.sram_din_o[8*b +: 8];
            end else dout1 <= mem1[bus1.sram_addr_o];
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int exp_lat(input logic k, input logic w);
        int wc = k ? 3 : 0;
        return w ? 1 + wc : 2 + wc + RdExtra;
    endfunction

    // One Wishbone transfer; returns measurements only.
    task automatic xfer(input logic k, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold, output int lat, output int csb_low,
                        output int ack_w, output logic [31:0] got);
        @(negedge clk);
        dut_sel = k; we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        lat = -1; csb_low = 0; ack_w = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!csb_m) csb_low++;
            if (ack_m) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
        got = dat_m;
        if (lat >= 0) ack_w = 1;
        if (!hold) begin
            @(negedge clk); cyc = 1'b0; stb = 1'b0;
        end
        @(posedge clk); #1;
        if (ack_m) ack_w++;
        if (!csb_m) csb_low++;
        if (hold) begin
            @(negedge clk); cyc = 1'b0; stb = 1'b0;
        end
        @(posedge clk); #1;
        if (ack_m) ack_w++;
        if (!csb_m) csb_low++;
        if (w) refmem[k][a] = merge(refmem[k][a], d, s);
        else   last_rd[k] = refmem[k][a];
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({bus0.wb_ack_o, bus0.sram_csb_o, bus0.sram_web_o, bus0.sram_wmask_o,
             bus0.sram_addr_o, bus0.sram_din_o, bus0.wb_dat_o} !== {3'b011, 76'h0}) begin
            bad++;
            $display("FAIL reset_dut0: got ack=%b csb=%b web=%b wm=%h adr=%h din=%h dat=%h want 0,1,1,0,0,0,0",
                     bus0.wb_ack_o, bus0.sram_csb_o, bus0.sram_web_o, bus0.sram_wmask_o,
                     bus0.sram_addr_o, bus0.sram_din_o, bus0.wb_dat_o);
        end
        total++;
        if ({bus1.wb_ack_o, bus1.sram_csb_o, bus1.sram_web_o, bus1.sram_wmask_o,
             bus1.sram_addr_o, bus1.sram_din_o, bus1.wb_dat_o} !== {3'b011, 76'h0}) begin
            bad++;
            $display("FAIL reset_dut1: got ack=%b csb=%b dat=%h want ack=0 csb=1 dat=0",
                     bus1.wb_ack_o, bus1.sram_csb_o, bus1.wb_dat_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus0.sram_csb_o !== 1'b1 || bus0.wb_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got csb=%b ack=%b want 1 0", bus0.sram_csb_o,
                     bus0.wb_ack_o);
        end
    endtask

    task automatic test_write_read;
        int lat, cl, aw;
        logic [31:0] got;
        xfer(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 1 || cl !== 1 || aw !== 1) begin
            bad++;
            $display("FAIL wr_basic: got lat=%0d csb=%0d ackw=%0d want 1 1 1", lat, cl, aw);
        end
        xfer(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 2 + RdExtra || cl !== 1 || aw !== 1) begin
            bad++;
            $display("FAIL rd_basic: got lat=%0d csb=%0d ackw=%0d want %0d 1 1", lat, cl, aw,
                     2 + RdExtra);
        end
        total++;
        if (got !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_data: got %h want deadbeef", got);
        end
    endtask

    task automatic test_byte_mask;
        int lat, cl, aw;
        logic [31:0] got;
        xfer(1'b0, 1'b1, 8'h10, 32'h11223344, 4'hF, 1'b0, lat, cl, aw, got);
        xfer(1'b0, 1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 1'b0, lat, cl, aw, got);
        total++;
        if (got !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_keeps_dat: got %h want deadbeef", got);
        end
        xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (got !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_mask: got %h want 11bb33dd", got);
        end
        xfer(1'b0, 1'b1, 8'h10, 32'h55667788, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 1 || aw !== 1) begin
            bad++;
            $display("FAIL sel0_ack: got lat=%0d ackw=%0d want 1 1", lat, aw);
        end
        xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (got !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL sel0_data: got %h want 11bb33dd", got);
        end
    endtask

    task automatic test_wait_states;
        int lat, cl, aw;
        logic [31:0] got;
        xfer(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 5 + RdExtra || aw !== 1 || cl !== 1) begin
            bad++;
            $display("FAIL wait_rd: got lat=%0d ackw=%0d csb=%0d want %0d 1 1", lat, aw, cl,
                     5 + RdExtra);
        end
        xfer(1'b1, 1'b1, 8'hFF, 32'hCAFEF00D, 4'hF, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 4 || aw !== 1 || cl !== 1) begin
            bad++;
            $display("FAIL wait_wr: got lat=%0d ackw=%0d csb=%0d want 4 1 1", lat, aw, cl);
        end
        xfer(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (got !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL wait_data: got %h want cafef00d", got);
        end
    endtask

    task automatic test_abort;
        int acks = 0;
        int lat, cl, aw;
        logic [31:0] got;
        @(negedge clk);
        dut_sel = 1'b0; we = 1'b0; adr = 8'h05; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack_m) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL abort_ack: got %0d acks want 0", acks);
        end
        last_rd[0] = refmem[0][8'h05];
        total++;
        if (dat_m !== last_rd[0]) begin
            bad++;
            $display("FAIL abort_dat: got %h want %h", dat_m, last_rd[0]);
        end
        xfer(1'b0, 1'b1, 8'h00, 32'h0BADF00D, 4'hF, 1'b0, lat, cl, aw, got);
        total++;
        if (lat !== 1 || aw !== 1) begin
            bad++;
            $display("FAIL abort_next: got lat=%0d ackw=%0d want 1 1", lat, aw);
        end
    endtask

    task automatic test_reset_mid;
        int lat, cl, aw;
        logic [31:0] got;
        xfer(1'b0, 1'b1, 8'h20, 32'h13579BDF, 4'hF, 1'b0, lat, cl, aw, got);
        @(negedge clk);
        dut_sel = 1'b0; we = 1'b0; adr = 8'h05; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        total++;
        if (bus0.sram_csb_o !== 1'b1 || bus0.wb_ack_o !== 1'b0 || bus0.wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: got csb=%b ack=%b dat=%h want 1 0 0", bus0.sram_csb_o,
                     bus0.wb_ack_o, bus0.wb_dat_o);
        end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        xfer(1'b0, 1'b0, 8'h20, 32'h0, 4'h0, 1'b0, lat, cl, aw, got);
        total++;
        if (got !== 32'h13579BDF || lat !== 2 + RdExtra) begin
            bad++;
            $display("FAIL rst_recover: got %h lat=%0d want 13579bdf lat=%0d", got, lat,
                     2 + RdExtra);
        end
    endtask

    task automatic test_back_to_back;
        int lat, cl, aw, a0;
        logic [31:0] got;
        a0 = acc0;
        xfer(1'b0, 1'b1, 8'h30, 32'h24681357, 4'hF, 1'b1, lat, cl, aw, got);
        total++;
        if (acc0 - a0 !== 1 || aw !== 1 || lat !== 1) begin
            bad++;
            $display("FAIL b2b_wr: got acc=%0d ackw=%0d lat=%0d want 1 1 1", acc0 - a0, aw, lat);
        end
        a0 = acc0;
        xfer(1'b0, 1'b0, 8'h30, 32'h0, 4'h0, 1'b1, lat, cl, aw, got);
        total++;
        if (acc0 - a0 !== 1 || aw !== 1 || got !== 32'h24681357) begin
            bad++;
            $display("FAIL b2b_rd: got acc=%0d ackw=%0d dat=%h want 1 1 24681357", acc0 - a0,
                     aw, got);
        end
    endtask

    task automatic test_random;
        int lat, cl, aw;
        logic [31:0] got, d;
        logic k, w;
        logic [7:0] a;
        logic [3:0] s;
        for (int n = 0; n < 40; n++) begin
            k = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            xfer(k, w, a, d, s, 1'($urandom_range(0, 1)), lat, cl, aw, got);
            total++;
            if (lat !== exp_lat(k, w) || cl !== 1 || aw !== 1) begin
                bad++;
                $display("FAIL rnd_timing[%0d]: dut%0d we=%b got lat=%0d csb=%0d ackw=%0d want %0d 1 1",
                         n, k, w, lat, cl, aw, exp_lat(k, w));
            end
            total++;
            if (got !== last_rd[k]) begin
                bad++;
                $display("FAIL rnd_data[%0d]: dut%0d we=%b adr=%h got %h want %h", n, k, w, a,
                         got, last_rd[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_wait_states();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end within the time limit");
        $fatal(1, "timeout");
    end
endmodule
